// File: rtl/riscv_core_mdu_issue_if.sv
// Execute/writeback-side bundle for the M-extension issue front end.
// slave = issue block, master = execute/unit/writeback environment.
interface riscv_core_mdu_issue_if #(
  parameter int XLEN = 64,
  parameter int RD_W = 5
);
  logic            i_mdu_issue_valid;
  logic            o_mdu_issue_ready;
  logic [XLEN-1:0] i_mdu_issue_srcA;
  logic [XLEN-1:0] i_mdu_issue_srcB;
  logic [3:0]      i_mdu_issue_control;
  logic            i_mdu_issue_isword;
  logic [RD_W-1:0] i_mdu_issue_rd;
  logic            i_mdu_issue_flush;
  logic [XLEN-1:0] o_mdu_issue_md_srcA;
  logic [XLEN-1:0] o_mdu_issue_md_srcB;
  logic [3:0]      o_mdu_issue_md_control;
  logic            o_mdu_issue_md_isword;
  logic            o_mdu_issue_md_en;
  logic            i_mdu_issue_md_done;
  logic [XLEN-1:0] i_mdu_issue_md_result;
  logic            i_mdu_issue_md_overflow;
  logic            i_mdu_issue_md_div_by_zero;
  logic            o_mdu_issue_busy;
  logic            o_mdu_issue_wb_valid;
  logic            i_mdu_issue_wb_ready;
  logic [RD_W-1:0] o_mdu_issue_wb_rd;
  logic [XLEN-1:0] o_mdu_issue_wb_result;
  logic            o_mdu_issue_wb_overflow;
  logic            o_mdu_issue_wb_div_by_zero;

  modport slave (
    input  i_mdu_issue_valid, i_mdu_issue_srcA, i_mdu_issue_srcB, i_mdu_issue_control,
           i_mdu_issue_isword, i_mdu_issue_rd, i_mdu_issue_flush, i_mdu_issue_md_done,
           i_mdu_issue_md_result, i_mdu_issue_md_overflow, i_mdu_issue_md_div_by_zero,
           i_mdu_issue_wb_ready,
    output o_mdu_issue_ready, o_mdu_issue_md_srcA, o_mdu_issue_md_srcB, o_mdu_issue_md_control,
           o_mdu_issue_md_isword, o_mdu_issue_md_en, o_mdu_issue_busy, o_mdu_issue_wb_valid,
           o_mdu_issue_wb_rd, o_mdu_issue_wb_result, o_mdu_issue_wb_overflow,
           o_mdu_issue_wb_div_by_zero
  );

  modport master (
    output i_mdu_issue_valid, i_mdu_issue_srcA, i_mdu_issue_srcB, i_mdu_issue_control,
           i_mdu_issue_isword, i_mdu_issue_rd, i_mdu_issue_flush, i_mdu_issue_md_done,
           i_mdu_issue_md_result, i_mdu_issue_md_overflow, i_mdu_issue_md_div_by_zero,
           i_mdu_issue_wb_ready,
    input  o_mdu_issue_ready, o_mdu_issue_md_srcA, o_mdu_issue_md_srcB, o_mdu_issue_md_control,
           o_mdu_issue_md_isword, o_mdu_issue_md_en, o_mdu_issue_busy, o_mdu_issue_wb_valid,
           o_mdu_issue_wb_rd, o_mdu_issue_wb_result, o_mdu_issue_wb_overflow,
           o_mdu_issue_wb_div_by_zero
  );
endinterface

// File: rtl/riscv_core_mdu_issue.sv
// Issue/hold front end for the M-extension unit: latch op, pulse enable, hold result for writeback.
// Optional perf counters (ops_cnt, busy_cnt) are built when RISCV_MDU_ISSUE_PERF_EN is defined.
module riscv_core_mdu_issue #(
  parameter int XLEN = 64,
  parameter int RD_W = 5
) (
  input  logic                  i_mdu_issue_clk,
  input  logic                  i_mdu_issue_rstn,
  riscv_core_mdu_issue_if.slave bus
`ifdef RISCV_MDU_ISSUE_PERF_EN
  ,
  output logic [31:0]           o_mdu_issue_ops_cnt,
  output logic [31:0]           o_mdu_issue_busy_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            w_accept;
  logic            w_capture;

  logic [XLEN-1:0] r_src_a;
  logic [XLEN-1:0] r_src_b;
  logic [3:0]      r_control;
  logic            r_isword;
  logic [RD_W-1:0] r_rd;
  logic [XLEN-1:0] r_result;
  logic            r_overflow;
  logic            r_div_by_zero;
  logic            r_md_en;
  logic            r_wb_valid;
  logic            r_busy;
  logic            r_ready;

  // Next-state decode; the unit cannot be aborted, so a flush before done goes through DRAIN.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.i_mdu_issue_valid && !bus.i_mdu_issue_flush) begin
          w_state_nxt = S_ISSUE;
          w_accept    = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ISSUE, S_WAIT: begin
        if (bus.i_mdu_issue_flush) begin
          w_state_nxt = bus.i_mdu_issue_md_done ? S_IDLE : S_DRAIN;
        end else if (bus.i_mdu_issue_md_done) begin
          w_state_nxt = S_HOLD;
          w_capture   = 1'b1;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_HOLD: begin
        if (bus.i_mdu_issue_flush || bus.i_mdu_issue_wb_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_HOLD;
        end
      end
      S_DRAIN: begin
        if (bus.i_mdu_issue_md_done) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DRAIN;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register plus status outputs registered from the next state.
  always_ff @(posedge i_mdu_issue_clk or negedge i_mdu_issue_rstn) begin
    if (!i_mdu_issue_rstn) begin
      r_state    <= S_IDLE;
      r_md_en    <= 1'b0;
      r_wb_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_ready    <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_md_en    <= (w_state_nxt == S_ISSUE);
      r_wb_valid <= (w_state_nxt == S_HOLD);
      r_busy     <= (w_state_nxt != S_IDLE);
      r_ready    <= (w_state_nxt == S_IDLE);
    end
  end

  // Operand latch: written only on accept, so the unit sees stable inputs until done.
  always_ff @(posedge i_mdu_issue_clk or negedge i_mdu_issue_rstn) begin
    if (!i_mdu_issue_rstn) begin
      r_src_a   <= '0;
      r_src_b   <= '0;
      r_control <= 4'd0;
      r_isword  <= 1'b0;
      r_rd      <= '0;
    end else if (w_accept) begin
      r_src_a   <= bus.i_mdu_issue_srcA;
      r_src_b   <= bus.i_mdu_issue_srcB;
      r_control <= bus.i_mdu_issue_control;
      r_isword  <= bus.i_mdu_issue_isword;
      r_rd      <= bus.i_mdu_issue_rd;
    end
  end

  // Result holding register: stray done pulses in IDLE/HOLD/DRAIN never reach it.
  always_ff @(posedge i_mdu_issue_clk or negedge i_mdu_issue_rstn) begin
    if (!i_mdu_issue_rstn) begin
      r_result      <= '0;
      r_overflow    <= 1'b0;
      r_div_by_zero <= 1'b0;
    end else if (w_capture) begin
      r_result      <= bus.i_mdu_issue_md_result;
      r_overflow    <= bus.i_mdu_issue_md_overflow;
      r_div_by_zero <= bus.i_mdu_issue_md_div_by_zero;
    end
  end

  assign bus.o_mdu_issue_ready          = r_ready;
  assign bus.o_mdu_issue_busy           = r_busy;
  assign bus.o_mdu_issue_md_en          = r_md_en;
  assign bus.o_mdu_issue_md_srcA        = r_src_a;
  assign bus.o_mdu_issue_md_srcB        = r_src_b;
  assign bus.o_mdu_issue_md_control     = r_control;
  assign bus.o_mdu_issue_md_isword      = r_isword;
  assign bus.o_mdu_issue_wb_valid       = r_wb_valid;
  assign bus.o_mdu_issue_wb_rd          = r_rd;
  assign bus.o_mdu_issue_wb_result      = r_result;
  assign bus.o_mdu_issue_wb_overflow    = r_overflow;
  assign bus.o_mdu_issue_wb_div_by_zero = r_div_by_zero;

`ifdef RISCV_MDU_ISSUE_PERF_EN
  logic        w_wb_fire;
  logic [31:0] r_ops_cnt;
  logic [31:0] r_busy_cnt;

  assign w_wb_fire = (r_state == S_HOLD) && bus.i_mdu_issue_wb_ready && !bus.i_mdu_issue_flush;

  // Saturating performance counters.
  always_ff @(posedge i_mdu_issue_clk or negedge i_mdu_issue_rstn) begin
    if (!i_mdu_issue_rstn) begin
      r_ops_cnt  <= 32'd0;
      r_busy_cnt <= 32'd0;
    end else begin
      if (w_wb_fire && (r_ops_cnt != 32'hFFFF_FFFF)) begin
        r_ops_cnt <= r_ops_cnt + 32'd1;
      end
      if (r_busy && (r_busy_cnt != 32'hFFFF_FFFF)) begin
        r_busy_cnt <= r_busy_cnt + 32'd1;
      end
    end
  end

  assign o_mdu_issue_ops_cnt  = r_ops_cnt;
  assign o_mdu_issue_busy_cnt = r_busy_cnt;
`endif

endmodule

// File: tb/tb_riscv_core_mdu_issue.sv
// Self-checking bench for riscv_core_mdu_issue; the bench also plays the M-unit using a
// behavioural RISC-V M-extension model fed from the DUT's md_* outputs.
module tb_riscv_core_mdu_issue;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  riscv_core_mdu_issue_if #(.XLEN(64), .RD_W(5)) bus ();

`ifdef RISCV_MDU_ISSUE_PERF_EN
  logic [31:0] ops_cnt;
  logic [31:0] busy_cnt;
`endif

  riscv_core_mdu_issue #(.XLEN(64), .RD_W(5)) dut (
    .i_mdu_issue_clk  (clk),
    .i_mdu_issue_rstn (rstn),
    .bus              (bus)
`ifdef RISCV_MDU_ISSUE_PERF_EN
    ,
    .o_mdu_issue_ops_cnt  (ops_cnt),
    .o_mdu_issue_busy_cnt (busy_cnt)
`endif
  );

  // RISC-V M semantics: returns {overflow, div_by_zero, result}.
  function automatic logic [65:0] m_ref(input logic [2:0] f3, input logic isw,
                                        input logic [63:0] a, input logic [63:0] b);
    logic [127:0] pa, pb, p;
    logic [63:0]  r;
    logic [31:0]  a32, b32, r32;
    logic         ov, dz;
    ov = 1'b0; dz = 1'b0; r = 64'd0; r32 = 32'd0;
    a32 = a[31:0]; b32 = b[31:0];
    if (!isw) begin
      case (f3)
        3'd0: r = a * b;
        3'd1: begin pa = {{64{a[63]}}, a}; pb = {{64{b[63]}}, b}; p = pa * pb; r = p[127:64]; end
        3'd2: begin pa = {{64{a[63]}}, a}; pb = {64'd0, b}; p = pa * pb; r = p[127:64]; end
        3'd3: begin pa = {64'd0, a}; pb = {64'd0, b}; p = pa * pb; r = p[127:64]; end
        3'd4: if (b == 64'd0) begin r = '1; dz = 1'b1; end
              else if (a == 64'h8000_0000_0000_0000 && b == '1) begin r = a; ov = 1'b1; end
              else r = $signed(a) / $signed(b);
        3'd5: if (b == 64'd0) begin r = '1; dz = 1'b1; end else r = a / b;
        3'd6: if (b == 64'd0) begin r = a; dz = 1'b1; end
              else if (a == 64'h8000_0000_0000_0000 && b == '1) begin r = 64'd0; ov = 1'b1; end
              else r = $signed(a) % $signed(b);
        default: if (b == 64'd0) begin r = a; dz = 1'b1; end else r = a % b;
      endcase
    end else begin
      case (f3)
        3'd4: if (b32 == 32'd0) begin r32 = '1; dz = 1'b1; end
              else if (a32 == 32'h8000_0000 && b32 == '1) begin r32 = a32; ov = 1'b1; end
              else r32 = $signed(a32) / $signed(b32);
        3'd5: if (b32 == 32'd0) begin r32 = '1; dz = 1'b1; end else r32 = a32 / b32;
        3'd6: if (b32 == 32'd0) begin r32 = a32; dz = 1'b1; end
              else if (a32 == 32'h8000_0000 && b32 == '1) begin r32 = 32'd0; ov = 1'b1; end
              else r32 = $signed(a32) % $signed(b32);
        3'd7: if (b32 == 32'd0) begin r32 = a32; dz = 1'b1; end else r32 = a32 % b32;
        default: r32 = a32 * b32;
      endcase
      r = {{32{r32[31]}}, r32};
    end
    return {ov, dz, r};
  endfunction

  task automatic init_inputs();
    bus.i_mdu_issue_valid          = 1'b0;
    bus.i_mdu_issue_srcA           = 64'd0;
    bus.i_mdu_issue_srcB           = 64'd0;
    bus.i_mdu_issue_control        = 4'd0;
    bus.i_mdu_issue_isword         = 1'b0;
    bus.i_mdu_issue_rd             = 5'd0;
    bus.i_mdu_issue_flush          = 1'b0;
    bus.i_mdu_issue_md_done        = 1'b0;
    bus.i_mdu_issue_md_result      = 64'd0;
    bus.i_mdu_issue_md_overflow    = 1'b0;
    bus.i_mdu_issue_md_div_by_zero = 1'b0;
    bus.i_mdu_issue_wb_ready       = 1'b0;
  endtask

  // Drives one op and acts as the unit (done lat cycles after md_en) and as writeback
  // (ready withheld for hold cycles, during which stray done pulses and srcA toggles occur).
  // Returns observations only; callers compare them. Starts and ends at a negedge.
  task automatic do_op(input logic [63:0] a, input logic [63:0] b, input logic [3:0] ctrl,
                       input logic isw, input logic [4:0] rd, input int lat, input int hold,
                       output logic [63:0] res, output logic ov, output logic dz,
                       output logic [4:0] rd_o, output int en_cyc, output int wbv_cyc,
                       output int hold_chg);
    logic [65:0] u;
    int hc;
    int w;
    en_cyc = -1; wbv_cyc = -1; hold_chg = 0; hc = 0;
    res = 64'd0; ov = 1'b0; dz = 1'b0; rd_o = 5'd0;
    w = 0;
    while (bus.o_mdu_issue_ready !== 1'b1 && w < 50) begin @(negedge clk); w++; end
    bus.i_mdu_issue_valid   = 1'b1;
    bus.i_mdu_issue_srcA    = a;
    bus.i_mdu_issue_srcB    = b;
    bus.i_mdu_issue_control = ctrl;
    bus.i_mdu_issue_isword  = isw;
    bus.i_mdu_issue_rd      = rd;
    for (int c = 1; c < 100; c++) begin
      @(negedge clk);
      bus.i_mdu_issue_valid   = 1'b0;
      bus.i_mdu_issue_md_done = 1'b0;
      bus.i_mdu_issue_wb_ready = 1'b0;
      if (bus.o_mdu_issue_md_en === 1'b1 && en_cyc < 0) en_cyc = c;
      if (c == 1 + lat) begin
        u = m_ref(bus.o_mdu_issue_md_control[2:0], bus.o_mdu_issue_md_isword,
                  bus.o_mdu_issue_md_srcA, bus.o_mdu_issue_md_srcB);
        bus.i_mdu_issue_md_done        = 1'b1;
        bus.i_mdu_issue_md_result      = u[63:0];
        bus.i_mdu_issue_md_div_by_zero = u[64];
        bus.i_mdu_issue_md_overflow    = u[65];
      end
      if (bus.o_mdu_issue_wb_valid === 1'b1) begin
        if (wbv_cyc < 0) begin
          wbv_cyc = c;
          res  = bus.o_mdu_issue_wb_result;
          ov   = bus.o_mdu_issue_wb_overflow;
          dz   = bus.o_mdu_issue_wb_div_by_zero;
          rd_o = bus.o_mdu_issue_wb_rd;
        end else if (bus.o_mdu_issue_wb_result !== res || bus.o_mdu_issue_wb_rd !== rd_o ||
                     bus.o_mdu_issue_wb_overflow !== ov || bus.o_mdu_issue_wb_div_by_zero !== dz) begin
          hold_chg++;
        end
        if (bus.o_mdu_issue_ready !== 1'b0) hold_chg++;
        if (hc < hold) begin
          hc++;
          bus.i_mdu_issue_srcA           = {$urandom, $urandom};
          bus.i_mdu_issue_md_done        = 1'b1;
          bus.i_mdu_issue_md_result      = {$urandom, $urandom};
          bus.i_mdu_issue_md_overflow    = ~ov;
          bus.i_mdu_issue_md_div_by_zero = ~dz;
        end else begin
          bus.i_mdu_issue_wb_ready = 1'b1;
          @(negedge clk);
          bus.i_mdu_issue_wb_ready = 1'b0;
          break;
        end
      end
    end
    bus.i_mdu_issue_md_done = 1'b0;
  endtask

  task automatic test_reset();
    init_inputs();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.o_mdu_issue_busy !== 1'b0 || bus.o_mdu_issue_md_en !== 1'b0 ||
        bus.o_mdu_issue_wb_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_ctrl busy=%b md_en=%b wb_valid=%b exp 0 0 0",
               bus.o_mdu_issue_busy, bus.o_mdu_issue_md_en, bus.o_mdu_issue_wb_valid);
    end
    n_checks++;
    if (bus.o_mdu_issue_wb_result !== 64'd0 || bus.o_mdu_issue_md_srcA !== 64'd0 ||
        bus.o_mdu_issue_wb_rd !== 5'd0) begin
      n_errors++;
      $display("FAIL reset_data wb_result=%h md_srcA=%h wb_rd=%h exp 0",
               bus.o_mdu_issue_wb_result, bus.o_mdu_issue_md_srcA, bus.o_mdu_issue_wb_rd);
    end
    rstn = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.o_mdu_issue_ready !== 1'b1 || bus.o_mdu_issue_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_release ready=%b busy=%b exp 1 0", bus.o_mdu_issue_ready, bus.o_mdu_issue_busy);
    end
  endtask

  task automatic test_mul();
    logic [63:0] res; logic ov, dz; logic [4:0] rdo; int en_c, wb_c, hch;
    do_op(64'd7, 64'd6, 4'h0, 1'b0, 5'd9, 3, 0, res, ov, dz, rdo, en_c, wb_c, hch);
    n_checks++;
    if (en_c !== 1 || wb_c !== 5) begin
      n_errors++;
      $display("FAIL mul_latency md_en_cycle=%0d wb_valid_cycle=%0d exp 1 5", en_c, wb_c);
    end
    n_checks++;
    if (res !== 64'd42 || rdo !== 5'd9 || ov !== 1'b0 || dz !== 1'b0) begin
      n_errors++;
      $display("FAIL mul_result res=%h rd=%0d ov=%b dz=%b exp 2a 9 0 0", res, rdo, ov, dz);
    end
    n_checks++;
    if (bus.o_mdu_issue_ready !== 1'b1 || bus.o_mdu_issue_busy !== 1'b0 || bus.o_mdu_issue_wb_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL mul_idle ready=%b busy=%b wb_valid=%b exp 1 0 0",
               bus.o_mdu_issue_ready, bus.o_mdu_issue_busy, bus.o_mdu_issue_wb_valid);
    end
  endtask

  task automatic test_divu_zero();
    logic [63:0] res; logic ov, dz; logic [4:0] rdo; int en_c, wb_c, hch;
    do_op(64'd100, 64'd0, 4'h5, 1'b0, 5'd17, 0, 0, res, ov, dz, rdo, en_c, wb_c, hch);
    n_checks++;
    if (en_c !== 1 || wb_c !== 2) begin
      n_errors++;
      $display("FAIL divu0_latency md_en_cycle=%0d wb_valid_cycle=%0d exp 1 2", en_c, wb_c);
    end
    n_checks++;
    if (res !== 64'hFFFF_FFFF_FFFF_FFFF || dz !== 1'b1 || ov !== 1'b0 || rdo !== 5'd17) begin
      n_errors++;
      $display("FAIL divu0_result res=%h dz=%b ov=%b rd=%0d exp ffffffffffffffff 1 0 17", res, dz, ov, rdo);
    end
  endtask

  task automatic test_hold_stall();
    logic [63:0] res, a, b; logic ov, dz; logic [4:0] rdo; int en_c, wb_c, hch;
    a = {$urandom, $urandom}; b = {$urandom, $urandom};
    do_op(a, b, 4'h3, 1'b0, 5'd30, 1, 4, res, ov, dz, rdo, en_c, wb_c, hch);
    n_checks++;
    if (hch !== 0) begin
      n_errors++;
      $display("FAIL hold_stable changes=%0d exp 0", hch);
    end
    n_checks++;
    if (res !== m_ref(3'd3, 1'b0, a, b) || rdo !== 5'd30 || wb_c !== 3) begin
      n_errors++;
      $display("FAIL hold_result res=%h rd=%0d wb_cyc=%0d exp %h 30 3", res, rdo, wb_c, m_ref(3'd3, 1'b0, a, b));
    end
  endtask

  task automatic test_flush_wait();
    logic [63:0] a, b, res; logic ov, dz; logic [4:0] rdo; int en_c, wb_c, hch, seen_wbv, unstable;
    a = 64'h1234_5678_9ABC_DEF0; b = 64'h0FED_CBA9_8765_4321;
    seen_wbv = 0; unstable = 0;
    bus.i_mdu_issue_valid = 1'b1; bus.i_mdu_issue_srcA = a; bus.i_mdu_issue_srcB = b;
    bus.i_mdu_issue_control = 4'h0; bus.i_mdu_issue_isword = 1'b0; bus.i_mdu_issue_rd = 5'd3;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      bus.i_mdu_issue_valid = 1'b0;
      bus.i_mdu_issue_flush = (c == 2);
      bus.i_mdu_issue_md_done = (c == 4);
      bus.i_mdu_issue_md_result = 64'h55;
      bus.i_mdu_issue_srcA = ~a;
      if (bus.o_mdu_issue_wb_valid !== 1'b0) seen_wbv++;
      if (c <= 4 && (bus.o_mdu_issue_md_srcA !== a || bus.o_mdu_issue_md_srcB !== b)) unstable++;
    end
    bus.i_mdu_issue_md_done = 1'b0;
    n_checks++;
    if (seen_wbv !== 0) begin
      n_errors++;
      $display("FAIL flush_wbv wb_valid_cycles=%0d exp 0", seen_wbv);
    end
    n_checks++;
    if (unstable !== 0) begin
      n_errors++;
      $display("FAIL flush_operands unstable_cycles=%0d exp 0", unstable);
    end
    n_checks++;
    if (bus.o_mdu_issue_busy !== 1'b0 || bus.o_mdu_issue_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL flush_idle busy=%b ready=%b exp 0 1", bus.o_mdu_issue_busy, bus.o_mdu_issue_ready);
    end
    do_op(64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 4'h0, 1'b1, 5'd4, 2, 0, res, ov, dz, rdo, en_c, wb_c, hch);
    n_checks++;
    if (res !== 64'hFFFF_FFFF_FFFF_FFFA || rdo !== 5'd4) begin
      n_errors++;
      $display("FAIL flush_next_mulw res=%h rd=%0d exp fffffffffffffffa 4", res, rdo);
    end
  endtask

  task automatic test_flush_hold();
    // valid together with flush in IDLE must be ignored
    bus.i_mdu_issue_valid = 1'b1; bus.i_mdu_issue_flush = 1'b1;
    @(negedge clk);
    bus.i_mdu_issue_valid = 1'b0; bus.i_mdu_issue_flush = 1'b0;
    n_checks++;
    if (bus.o_mdu_issue_busy !== 1'b0 || bus.o_mdu_issue_md_en !== 1'b0) begin
      n_errors++;
      $display("FAIL idle_flush_ignored busy=%b md_en=%b exp 0 0", bus.o_mdu_issue_busy, bus.o_mdu_issue_md_en);
    end
    bus.i_mdu_issue_valid = 1'b1; bus.i_mdu_issue_srcA = 64'd5; bus.i_mdu_issue_srcB = 64'd5;
    bus.i_mdu_issue_control = 4'h0; bus.i_mdu_issue_isword = 1'b0;
    @(negedge clk);
    bus.i_mdu_issue_valid = 1'b0; bus.i_mdu_issue_md_done = 1'b1; bus.i_mdu_issue_md_result = 64'd25;
    @(negedge clk);
    bus.i_mdu_issue_md_done = 1'b0;
    n_checks++;
    if (bus.o_mdu_issue_wb_valid !== 1'b1 || bus.o_mdu_issue_wb_result !== 64'd25) begin
      n_errors++;
      $display("FAIL hold_enter wb_valid=%b res=%h exp 1 19", bus.o_mdu_issue_wb_valid, bus.o_mdu_issue_wb_result);
    end
    bus.i_mdu_issue_flush = 1'b1; bus.i_mdu_issue_wb_ready = 1'b1;
    @(negedge clk);
    bus.i_mdu_issue_flush = 1'b0; bus.i_mdu_issue_wb_ready = 1'b0;
    n_checks++;
    if (bus.o_mdu_issue_wb_valid !== 1'b0 || bus.o_mdu_issue_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL hold_flush wb_valid=%b ready=%b exp 0 1", bus.o_mdu_issue_wb_valid, bus.o_mdu_issue_ready);
    end
  endtask

  task automatic test_reset_midop();
    logic [63:0] res; logic ov, dz; logic [4:0] rdo; int en_c, wb_c, hch;
    bus.i_mdu_issue_valid = 1'b1; bus.i_mdu_issue_srcA = 64'hABCD; bus.i_mdu_issue_srcB = 64'd9;
    bus.i_mdu_issue_control = 4'h4; bus.i_mdu_issue_rd = 5'd12;
    @(negedge clk);
    bus.i_mdu_issue_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b0;
    #1;
    n_checks++;
    if (bus.o_mdu_issue_busy !== 1'b0 || bus.o_mdu_issue_md_en !== 1'b0 || bus.o_mdu_issue_wb_valid !== 1'b0 ||
        bus.o_mdu_issue_md_srcA !== 64'd0 || bus.o_mdu_issue_md_srcB !== 64'd0 || bus.o_mdu_issue_wb_rd !== 5'd0) begin
      n_errors++;
      $display("FAIL midop_reset busy=%b md_en=%b wbv=%b srcA=%h srcB=%h rd=%0d exp all 0",
               bus.o_mdu_issue_busy, bus.o_mdu_issue_md_en, bus.o_mdu_issue_wb_valid,
               bus.o_mdu_issue_md_srcA, bus.o_mdu_issue_md_srcB, bus.o_mdu_issue_wb_rd);
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.o_mdu_issue_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL midop_release ready=%b exp 1", bus.o_mdu_issue_ready);
    end
    do_op(64'd1000, 64'd7, 4'h6, 1'b0, 5'd12, 1, 0, res, ov, dz, rdo, en_c, wb_c, hch);
    n_checks++;
    if (res !== 64'd6 || rdo !== 5'd12 || wb_c !== 3) begin
      n_errors++;
      $display("FAIL midop_next res=%h rd=%0d wb_cyc=%0d exp 6 12 3", res, rdo, wb_c);
    end
  endtask

  task automatic test_random();
    logic [63:0] a, b, res; logic ov, dz, isw; logic [4:0] rd, rdo; logic [3:0] ctrl;
    logic [65:0] e; int en_c, wb_c, hch, lat, hold, sel;
    for (int i = 0; i < 30; i++) begin
      isw = 1'($urandom_range(0, 1));
      ctrl[3] = 1'($urandom_range(0, 1));
      if (isw) ctrl[2:0] = ($urandom_range(0, 4) == 0) ? 3'd0 : 3'($urandom_range(4, 7));
      else     ctrl[2:0] = 3'($urandom_range(0, 7));
      a = {$urandom, $urandom}; b = {$urandom, $urandom};
      sel = $urandom_range(0, 5);
      if (sel == 0) b = 64'd0;
      if (sel == 1) begin
        b = '1;
        a = isw ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
      end
      rd = 5'($urandom_range(0, 31));
      lat = $urandom_range(0, 4); hold = $urandom_range(0, 2);
      e = m_ref(ctrl[2:0], isw, a, b);
      do_op(a, b, ctrl, isw, rd, lat, hold, res, ov, dz, rdo, en_c, wb_c, hch);
      n_checks++;
      if (res !== e[63:0] || dz !== e[64] || ov !== e[65] || rdo !== rd) begin
        n_errors++;
        $display("FAIL rand_result op%0d f3=%0d w=%b res=%h ov=%b dz=%b rd=%0d exp %h %b %b %0d",
                 i, ctrl[2:0], isw, res, ov, dz, rdo, e[63:0], e[65], e[64], rd);
      end
      n_checks++;
      if (en_c !== 1 || wb_c !== 2 + lat || hch !== 0) begin
        n_errors++;
        $display("FAIL rand_timing op%0d en=%0d wbv=%0d hold_chg=%0d exp 1 %0d 0", i, en_c, wb_c, hch, 2 + lat);
      end
    end
  endtask

`ifdef RISCV_MDU_ISSUE_PERF_EN
  task automatic test_perf();
    logic [63:0] res; logic ov, dz; logic [4:0] rdo; int en_c, wb_c, hch;
    logic [31:0] ops0, busy0;
    ops0 = ops_cnt; busy0 = busy_cnt;
    do_op(64'd2, 64'd3, 4'h0, 1'b0, 5'd1, 1, 0, res, ov, dz, rdo, en_c, wb_c, hch);
    bus.i_mdu_issue_valid = 1'b1; bus.i_mdu_issue_srcA = 64'd4; bus.i_mdu_issue_srcB = 64'd4;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      bus.i_mdu_issue_valid = 1'b0;
      bus.i_mdu_issue_flush = (c == 2);
      bus.i_mdu_issue_md_done = (c == 4);
    end
    bus.i_mdu_issue_md_done = 1'b0;
    do_op(64'd9, 64'd3, 4'h5, 1'b0, 5'd2, 2, 1, res, ov, dz, rdo, en_c, wb_c, hch);
    n_checks++;
    if (ops_cnt - ops0 !== 32'd2) begin
      n_errors++;
      $display("FAIL perf_ops delta=%0d exp 2", ops_cnt - ops0);
    end
    n_checks++;
    if (busy_cnt - busy0 !== 32'd12) begin
      n_errors++;
      $display("FAIL perf_busy delta=%0d exp 12", busy_cnt - busy0);
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_mul();
    test_divu_zero();
    test_hold_stall();
    test_flush_wait();
    test_flush_hold();
    test_reset_midop();
    test_random();
`ifdef RISCV_MDU_ISSUE_PERF_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
